// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with IF/ID register, stall hold buffer and flush redirect
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic        IFID_WRITE,
  input  logic        FLUSH,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IF_PC_OUT,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_INSTR,
  output logic        IFID_VALID
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] hold_q, hold_d;
  logic        advance;

  // Both the pipeline register and the PC must be free for an instruction to move on.
  assign advance = PC_WRITE & IFID_WRITE;

  // Next-state logic: flush outranks everything once fetching has started.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    hold_d       = hold_q;
    if (state_q == S_IDLE) begin
      state_d = S_FETCH;
    end else if (FLUSH) begin
      // Redirect to the word-aligned target; any in-flight or buffered word is dropped.
      state_d      = S_FETCH;
      pc_d         = BRANCH_TARGET & 32'hFFFF_FFFC;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      hold_d       = 32'h0000_0000;
    end else if (state_q == S_FETCH) begin
      if (IMEM_ACK) begin
        if (advance) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = IMEM_RDATA;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
        end else begin
          // Park the returned word so the stall does not cost a second memory read.
          hold_d  = IMEM_RDATA;
          state_d = S_HOLD;
        end
      end else if (IFID_WRITE) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end else if (state_q == S_HOLD) begin
      if (advance) begin
        ifid_pc_d    = pc_q;
        ifid_instr_d = hold_q;
        ifid_valid_d = 1'b1;
        pc_d         = pc_q + 32'd4;
        state_d      = S_FETCH;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      hold_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign IMEM_REQ   = (state_q == S_FETCH);
  assign IMEM_ADDR  = pc_q;
  assign IF_PC_OUT  = pc_q;
  assign IFID_PC    = ifid_pc_q;
  assign IFID_INSTR = ifid_instr_q;
  assign IFID_VALID = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with reference model
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        CLK, RST, PC_WRITE, IFID_WRITE, FLUSH, IMEM_ACK;
  logic [31:0] BRANCH_TARGET, IMEM_RDATA;
  logic        IMEM_REQ, IFID_VALID;
  logic [31:0] IMEM_ADDR, IF_PC_OUT, IFID_PC, IFID_INSTR;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE),
    .FLUSH(FLUSH), .BRANCH_TARGET(BRANCH_TARGET), .IMEM_REQ(IMEM_REQ),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .IF_PC_OUT(IF_PC_OUT), .IFID_PC(IFID_PC), .IFID_INSTR(IFID_INSTR),
    .IFID_VALID(IFID_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory returns a word derived from the address it is presented with.
  assign IMEM_RDATA = IMEM_ADDR ^ KEY;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic        req;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: "started" means the first post-reset edge has passed,
  // "parked" means a fetched word is waiting for the stall to clear.
  logic        m_started, m_parked;
  logic [31:0] m_buf, m_pc, m_ipc, m_instr;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_parked = 1'b0; m_buf = 32'h0;
    m_pc = RST_PC; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic pw, input logic iw, input logic fl,
                            input logic [31:0] bt, input logic ak);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (fl) begin
      m_pc = {bt[31:2], 2'b00};
      m_valid = 1'b0; m_instr = NOP; m_parked = 1'b0; m_buf = 32'h0;
    end else if (m_parked) begin
      if (pw && iw) begin
        m_ipc = m_pc; m_instr = m_buf; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_parked = 1'b0;
      end
    end else if (ak) begin
      if (pw && iw) begin
        m_ipc = m_pc; m_instr = m_pc ^ KEY; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        m_buf = m_pc ^ KEY; m_parked = 1'b1;
      end
    end else if (iw) begin
      m_valid = 1'b0; m_instr = NOP;
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, advance.
  task automatic step(input logic pw, input logic iw, input logic fl,
                      input logic [31:0] bt, input logic ak);
    exp_t e;
    PC_WRITE = pw; IFID_WRITE = iw; FLUSH = fl; BRANCH_TARGET = bt; IMEM_ACK = ak;
    model_edge(pw, iw, fl, bt, ak);
    e.pc = m_pc; e.ipc = m_ipc; e.instr = m_instr; e.valid = m_valid;
    e.req = m_started && !m_parked;
    sb_q.push_back(e);
    @(negedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc"}, IF_PC_OUT, RST_PC);
    chk({tag, "_addr"}, IMEM_ADDR, RST_PC);
    chk({tag, "_ifid_pc"}, IFID_PC, 32'h0);
    chk({tag, "_ifid_instr"}, IFID_INSTR, NOP);
    chk({tag, "_ifid_valid"}, {31'b0, IFID_VALID}, 32'h0);
    chk({tag, "_req"}, {31'b0, IMEM_REQ}, 32'h0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, away from the active edge.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("pc", IF_PC_OUT, e.pc);
      chk("imem_addr", IMEM_ADDR, e.pc);
      chk("ifid_pc", IFID_PC, e.ipc);
      chk("ifid_instr", IFID_INSTR, e.instr);
      chk("ifid_valid", {31'b0, IFID_VALID}, {31'b0, e.valid});
      chk("imem_req", {31'b0, IMEM_REQ}, {31'b0, e.req});
    end
  end

  initial begin
    PC_WRITE = 1'b1; IFID_WRITE = 1'b1; FLUSH = 1'b0; BRANCH_TARGET = 32'h0; IMEM_ACK = 1'b0;
    RST = 1'b1;
    #2 RST = 1'b0;
    repeat (5) @(negedge CLK);
    #1;
    check_reset("reset");
    RST = 1'b1;
    model_reset();

    // Streaming fetch: IDLE edge, then 0,4,8,12.
    step(1, 1, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h0, 1);
    // Three unacknowledged cycles at 0x10 give bubbles, then the word arrives.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 1);
    // Stall with an ack at 0x20, then release without asking memory again.
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 1);
    // Flush while parked, then flush while stalled in fetch, then fetch at 0x100.
    step(1, 0, 0, 32'h0, 1);
    step(1, 1, 1, 32'h0000_0103, 1);
    step(0, 0, 0, 32'h0, 0);
    step(0, 1, 1, 32'h0000_0103, 1);
    step(1, 1, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 1);
    // Wrap from the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFFF, 0);
    step(1, 1, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt;
      bt = $urandom;
      if ($urandom_range(0, 7) == 0) bt = 32'hFFFF_FFF0 | (bt & 32'hF);
      step($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 15) == 0, bt, $urandom_range(0, 3) != 0);
    end

    // Reset dropped between edges while parked.
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 0);
    #2 RST = 1'b0;
    #1 check_reset("async_reset");
    PC_WRITE = 1'b1; IFID_WRITE = 1'b1; IMEM_ACK = 1'b1;
    @(posedge CLK);
    #1 check_reset("reset_edge");
    @(negedge CLK);
    #1 RST = 1'b1;
    model_reset();
    step(1, 1, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h0, 1);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
